// File: rtl/udma_evt_pkg.sv
// Shared uDMA event definitions.
// Holds the event ID width and type used by the collector and the uDMA control block.
package udma_evt_pkg;

  localparam int EVT_ID_W = 8;

  typedef logic [EVT_ID_W-1:0] evt_id_t;

endpackage

// File: rtl/udma_evt_rr_arb.sv
// Combinational round-robin arbiter: picks the first request at or after ptr.
// Ports: req, ptr, en in; gnt_valid, gnt_idx out.
module udma_evt_rr_arb #(
  parameter int N  = 32,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic          gnt_valid,
  output logic [PW-1:0] gnt_idx
);

  int k;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    k         = 0;
    for (int i = 0; i < N; i++) begin
      // index (ptr + i) mod N; N need not be a power of two
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (en && !gnt_valid && req[k]) begin
        gnt_valid = 1'b1;
        gnt_idx   = PW'(k);
      end
    end
  end

endmodule

// File: rtl/udma_evt_collector.sv
// Collects event pulses, arbitrates them round-robin and queues 8-bit IDs.
// Ports: clk_i, rstn_i, evt_i, evt_valid_o/evt_data_o/evt_ready_i, lost_o, lost_clr_i, fifo_level_o.
module udma_evt_collector
  import udma_evt_pkg::*;
#(
  parameter int N_EVT      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int EVT_OFFSET = 0
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic [N_EVT-1:0]            evt_i,
  output logic                        evt_valid_o,
  output evt_id_t                     evt_data_o,
  input  logic                        evt_ready_i,
  output logic [N_EVT-1:0]            lost_o,
  input  logic [N_EVT-1:0]            lost_clr_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

  localparam int PW = $clog2(N_EVT);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [N_EVT-1:0] r_pend;
  logic [N_EVT-1:0] gnt_vec;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    gnt_idx;
  logic             gnt_valid;
  logic             push;
  logic             pop;
  logic             full;
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [AW:0]      level;
  evt_id_t          r_mem [FIFO_DEPTH];
  evt_id_t          r_last;
  evt_id_t          head;
  evt_id_t          push_data;

  // extra wrap bit makes wr - rd the exact occupancy
  assign level = r_wr - r_rd;
  assign full  = (level == (AW+1)'(FIFO_DEPTH));
  assign pop   = evt_valid_o & evt_ready_i;
  assign head  = r_mem[r_rd[AW-1:0]];

  udma_evt_rr_arb #(
    .N  (N_EVT),
    .PW (PW)
  ) u_arb (
    .req       (r_pend),
    .ptr       (r_ptr),
    .en        (~full | pop),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign push      = gnt_valid;
  assign gnt_vec   = push ? (N_EVT'(1) << gnt_idx) : '0;
  assign push_data = evt_id_t'(EVT_OFFSET + int'(gnt_idx));

  assign evt_valid_o  = (level != '0);
  // hold the last delivered ID while empty
  assign evt_data_o   = evt_valid_o ? head : r_last;
  assign fifo_level_o = level;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pend <= '0;
      lost_o <= '0;
      r_ptr  <= '0;
      r_wr   <= '0;
      r_rd   <= '0;
      r_last <= '0;
    end else begin
      // a new pulse on the granted source re-arms it
      r_pend <= (r_pend & ~gnt_vec) | evt_i;
      // a new loss beats a same-cycle clear
      lost_o <= (lost_o & ~lost_clr_i)
              | (evt_i & r_pend & ~gnt_vec);
      if (push) begin
        r_ptr <= (gnt_idx == PW'(N_EVT-1))
               ? '0 : gnt_idx + PW'(1);
        r_wr  <= r_wr + (AW+1)'(1);
      end
      if (pop) begin
        r_rd   <= r_rd + (AW+1)'(1);
        r_last <= head;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) r_mem[r_wr[AW-1:0]] <= push_data;
  end

endmodule

// File: tb/tb_udma_evt_collector.sv
// Scoreboard bench for udma_evt_collector (N_EVT=32, FIFO_DEPTH=4, EVT_OFFSET=0x10).
// Stimulus pushes expected IDs; a negedge monitor checks every handshake.
module tb_udma_evt_collector;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] evt;
  logic        valid;
  logic [7:0]  data;
  logic        ready;
  logic [31:0] lost;
  logic [31:0] lost_clr;
  logic [2:0]  level;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  udma_evt_collector #(
    .N_EVT      (32),
    .FIFO_DEPTH (4),
    .EVT_OFFSET (16)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .evt_i        (evt),
    .evt_valid_o  (valid),
    .evt_data_o   (data),
    .evt_ready_i  (ready),
    .lost_o       (lost),
    .lost_clr_i   (lost_clr),
    .fifo_level_o (level)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: compare every accepted ID against the scoreboard
  always @(negedge clk) begin
    if (rstn && valid && ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_id: got %0h expected none", data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data !== e) begin
          fails++;
          $display("FAIL id_order: got %0h expected %0h", data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: got %0d left expected 0", nm, exp_q.size());
    end
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn     = 1'b0;
    evt      = '0;
    ready    = 1'b0;
    lost_clr = '0;
    #1;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_data",  32'(data),  0);
    chk("rst_lost",  lost,       0);
    chk("rst_level", 32'(level), 0);
    repeat (2) @(posedge clk);
    #1;
    rstn  = 1'b1;
    ready = 1'b1;
    tick();

    // burst: all sources at once, pointer starts at 0
    evt = 32'hFFFF_FFFF;
    for (int i = 0; i < 32; i++) exp_q.push_back(8'(16 + i));
    tick();
    evt = '0;
    drain("burst_drain");
    chk("burst_lost", lost, 0);

    // backpressure: sources 0..5, FIFO takes 0..3, 4 and 5 stay pending
    ready = 1'b0;
    evt   = 32'h3F;
    for (int i = 0; i < 6; i++) exp_q.push_back(8'(16 + i));
    tick();
    evt = '0;
    repeat (5) tick();
    chk("bp_level", 32'(level), 4);
    chk("bp_valid", 32'(valid), 1);
    chk("bp_head",  32'(data),  32'h10);
    evt = 32'h20;
    tick();
    evt = '0;
    chk("bp_lost5", lost, 32'h20);
    // clear and new loss in the same cycle: loss wins
    evt      = 32'h20;
    lost_clr = 32'h20;
    tick();
    evt      = '0;
    lost_clr = '0;
    chk("clr_race", lost, 32'h20);
    lost_clr = 32'h20;
    tick();
    lost_clr = '0;
    chk("clr_alone", lost, 0);
    ready = 1'b1;
    drain("bp_drain");
    chk("bp_level_end", 32'(level), 0);

    // single event latency
    evt = 32'h20;
    exp_q.push_back(8'h15);
    tick();
    evt = '0;
    chk("lat_t1_valid", 32'(valid), 0);
    tick();
    chk("lat_t2_valid", 32'(valid), 1);
    chk("lat_t2_data",  32'(data),  32'h15);
    tick();
    chk("lat_t3_valid", 32'(valid), 0);
    chk("lat_hold_data", 32'(data), 32'h15);
    chk("lat_lost", lost, 0);

    // fairness: 0 and 3 every cycle for 8 cycles, pointer at 6.
    // grants alternate 0,3,...,0 (9 total); each source that waits
    // while re-pulsed records a loss, so lost ends at 0x9.
    evt = 32'h9;
    for (int i = 0; i < 9; i++) exp_q.push_back((i % 2) == 0 ? 8'h10 : 8'h13);
    repeat (8) tick();
    evt = '0;
    drain("rr_drain");
    chk("rr_lost", lost, 32'h9);
    lost_clr = 32'h9;
    tick();
    lost_clr = '0;
    chk("rr_lost_clr", lost, 0);

    // reset mid-burst: pointer at 1, sources 0..4, loss on 3
    ready = 1'b0;
    evt   = 32'h1F;
    tick();
    evt = 32'h8;
    tick();
    evt = '0;
    tick();
    tick();
    chk("pre_rst_level", 32'(level), 3);
    chk("pre_rst_lost",  lost, 32'h8);
    #2;
    rstn = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_valid", 32'(valid), 0);
    chk("arst_data",  32'(data),  0);
    chk("arst_lost",  lost,       0);
    chk("arst_level", 32'(level), 0);
    @(posedge clk);
    #1;
    rstn  = 1'b1;
    ready = 1'b1;
    tick();
    evt = 32'h4;
    exp_q.push_back(8'h12);
    tick();
    evt = '0;
    chk("post_t1_valid", 32'(valid), 0);
    tick();
    chk("post_t2_valid", 32'(valid), 1);
    chk("post_t2_data",  32'(data),  32'h12);
    drain("post_drain");
    repeat (4) tick();
    chk("post_no_stale", 32'(valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
